ex_stage_muldiv: RTL and testbench

//  Execute stage placed directly downstream of the ID/EX pipeline register; consumes its outputs.

---
 rtl/ex_stage_muldiv.sv | 201 ++++++++++++++++++++
 tb/tb_ex_stage_muldiv.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_muldiv.sv
// Execute stage: single-cycle ALU, branch/jump targets and an iterative unsigned MUL/DIVU,
// feeding an internal EX/MEM register. oStall freezes ID/EX while a MUL/DIVU is iterating.
module ex_stage_muldiv #(
    parameter int          DATA_W   = 32,
    parameter logic [3:0]  MUL_CODE = 4'b1000,
    parameter logic [3:0]  DIV_CODE = 4'b1001
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        iInstr,
    input  logic               iRegWrite,
    input  logic               iMemRead,
    input  logic               iMemWrite,
    input  logic               iMemToReg,
    input  logic               iBranch,
    input  logic               iJump,
    input  logic               iALUSrc,
    input  logic [3:0]         iALUCtrl,
    input  logic [DATA_W-1:0]  iA,
    input  logic [DATA_W-1:0]  iB,
    input  logic [DATA_W-1:0]  ioutSignEXT,
    input  logic [DATA_W-1:0]  iNPC1,
    input  logic [4:0]         iwriteRegWire,
    output logic               oStall,
    output logic               oRegWrite,
    output logic               oMemRead,
    output logic               oMemWrite,
    output logic               oMemToReg,
    output logic [DATA_W-1:0]  oALUOut,
    output logic               oZero,
    output logic [DATA_W-1:0]  oStoreData,
    output logic               oBranchTaken,
    output logic [DATA_W-1:0]  oBranchTarget,
    output logic               oJump,
    output logic [DATA_W-1:0]  oJumpTarget,
    output logic [4:0]         owriteRegWire
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             stateNext_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [DATA_W-1:0]  opA_r;
    logic [DATA_W-1:0]  opB_r;
    logic [DATA_W-1:0]  acc_r;
    logic               isDiv_r;

    logic [DATA_W-1:0]  opB_s;
    logic [DATA_W-1:0]  aluRes_s;
    logic [DATA_W-1:0]  exRes_s;
    logic               isMulDiv_s;
    logic               stall_s;
    logic               zero_s;
    logic [DATA_W:0]    remShift_s;
    logic [DATA_W:0]    remSub_s;
    logic               remGe_s;

    // Operand select and single-cycle ALU
    always_comb begin
        opB_s    = '0;
        aluRes_s = '0;
        if (iALUSrc) begin
            opB_s = ioutSignEXT;
        end else begin
            opB_s = iB;
        end
        case (iALUCtrl)
            4'b0000: aluRes_s = iA & opB_s;
            4'b0001: aluRes_s = iA | opB_s;
            4'b0010: aluRes_s = iA + opB_s;
            4'b0110: aluRes_s = iA - opB_s;
            4'b0111: aluRes_s = {{(DATA_W-1){1'b0}}, ($signed(iA) < $signed(opB_s))};
            4'b1100: aluRes_s = ~(iA | opB_s);
            default: aluRes_s = '0;
        endcase
    end

    assign isMulDiv_s = (iALUCtrl == MUL_CODE) || (iALUCtrl == DIV_CODE);

    // Restoring divide step: remainder lives in acc_r, dividend/quotient shifts through opA_r.
    // A zero divisor always "fits", which naturally yields an all-ones quotient.
    assign remShift_s = {acc_r, opA_r[DATA_W-1]};
    assign remSub_s   = remShift_s - {1'b0, opB_r};
    assign remGe_s    = (remShift_s >= {1'b0, opB_r});

    // MUL/DIVU sequencer next-state and stall request
    always_comb begin
        stateNext_s = state_r;
        stall_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (isMulDiv_s) begin
                    stall_s     = 1'b1;
                    stateNext_s = BUSY;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    stateNext_s = DONE;
                end else begin
                    stateNext_s = BUSY;
                end
            end
            DONE:    stateNext_s = IDLE;
            default: stateNext_s = IDLE;
        endcase
    end

    assign oStall  = stall_s & ~reset;
    assign exRes_s = (state_r == DONE) ? (isDiv_r ? opA_r : acc_r) : aluRes_s;
    assign zero_s  = (exRes_s == '0);

    // Sequencer state and iterative datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            opA_r   <= '0;
            opB_r   <= '0;
            acc_r   <= '0;
            isDiv_r <= 1'b0;
        end else begin
            state_r <= stateNext_s;
            case (state_r)
                IDLE: begin
                    if (isMulDiv_s) begin
                        opA_r   <= iA;
                        opB_r   <= opB_s;
                        acc_r   <= '0;
                        cnt_r   <= '0;
                        isDiv_r <= (iALUCtrl == DIV_CODE);
                    end
                end
                BUSY: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (isDiv_r) begin
                        opA_r <= {opA_r[DATA_W-2:0], remGe_s};
                        acc_r <= remGe_s ? remSub_s[DATA_W-1:0] : remShift_s[DATA_W-1:0];
                    end else begin
                        if (opB_r[0]) begin
                            acc_r <= acc_r + opA_r;
                        end
                        opA_r <= opA_r << 1;
                        opB_r <= opB_r >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // EX/MEM register; a stalled cycle loads a bubble into the control fields
    always_ff @(posedge clock) begin
        if (reset) begin
            oRegWrite     <= 1'b0;
            oMemRead      <= 1'b0;
            oMemWrite     <= 1'b0;
            oMemToReg     <= 1'b0;
            oALUOut       <= '0;
            oZero         <= 1'b0;
            oStoreData    <= '0;
            oBranchTaken  <= 1'b0;
            oBranchTarget <= '0;
            oJump         <= 1'b0;
            oJumpTarget   <= '0;
            owriteRegWire <= 5'd0;
        end else if (oStall) begin
            oRegWrite    <= 1'b0;
            oMemRead     <= 1'b0;
            oMemWrite    <= 1'b0;
            oMemToReg    <= 1'b0;
            oBranchTaken <= 1'b0;
            oJump        <= 1'b0;
        end else begin
            oRegWrite     <= iRegWrite;
            oMemRead      <= iMemRead;
            oMemWrite     <= iMemWrite;
            oMemToReg     <= iMemToReg;
            oALUOut       <= exRes_s;
            oZero         <= zero_s;
            oStoreData    <= iB;
            oBranchTaken  <= iBranch & zero_s;
            oBranchTarget <= iNPC1 + {ioutSignEXT[DATA_W-3:0], 2'b00};
            oJump         <= iJump;
            oJumpTarget   <= {iNPC1[31:28], iInstr[25:0], 2'b00};
            owriteRegWire <= iwriteRegWire;
        end
    end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Scoreboard bench for ex_stage_muldiv: the driver queues expected EX/MEM contents and stall
// lengths; independent monitors compare them when the stage produces a result.
module tb_ex_stage_muldiv;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] iInstr = 32'd0;
    logic        iRegWrite = 1'b0, iMemRead = 1'b0, iMemWrite = 1'b0, iMemToReg = 1'b0;
    logic        iBranch = 1'b0, iJump = 1'b0, iALUSrc = 1'b0;
    logic [3:0]  iALUCtrl = 4'd0;
    logic [31:0] iA = 32'd0, iB = 32'd0, ioutSignEXT = 32'd0, iNPC1 = 32'd0;
    logic [4:0]  iwriteRegWire = 5'd0;
    logic        oStall, oRegWrite, oMemRead, oMemWrite, oMemToReg, oZero, oBranchTaken, oJump;
    logic [31:0] oALUOut, oStoreData, oBranchTarget, oJumpTarget;
    logic [4:0]  owriteRegWire;

    typedef struct packed {
        logic        rw, mr, mw, m2r;
        logic [31:0] alu;
        logic        zero;
        logic [31:0] store;
        logic        bt;
        logic [31:0] btgt;
        logic        jump;
        logic [31:0] jtgt;
        logic [4:0]  wr;
    } resp_t;

    resp_t expQ[$];
    string nameQ[$];
    int    stallQ[$];
    int    checks = 0;
    int    errors = 0;
    logic  instValid = 1'b0;
    logic  pend = 1'b0;
    logic  bubble = 1'b0;
    int    stallRun = 0;

    ex_stage_muldiv dut (
        .clock(clock), .reset(reset), .iInstr(iInstr),
        .iRegWrite(iRegWrite), .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iMemToReg(iMemToReg),
        .iBranch(iBranch), .iJump(iJump), .iALUSrc(iALUSrc), .iALUCtrl(iALUCtrl),
        .iA(iA), .iB(iB), .ioutSignEXT(ioutSignEXT), .iNPC1(iNPC1), .iwriteRegWire(iwriteRegWire),
        .oStall(oStall), .oRegWrite(oRegWrite), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
        .oMemToReg(oMemToReg), .oALUOut(oALUOut), .oZero(oZero), .oStoreData(oStoreData),
        .oBranchTaken(oBranchTaken), .oBranchTarget(oBranchTarget), .oJump(oJump),
        .oJumpTarget(oJumpTarget), .owriteRegWire(owriteRegWire)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    function automatic resp_t actual();
        resp_t r;
        r = '{oRegWrite, oMemRead, oMemWrite, oMemToReg, oALUOut, oZero, oStoreData,
              oBranchTaken, oBranchTarget, oJump, oJumpTarget, owriteRegWire};
        return r;
    endfunction

    // Stall-run and response-present tracking on the active edge
    always @(posedge clock) begin
        if (reset) begin
            stallRun = 0;
            pend     = 1'b0;
            bubble   = 1'b0;
        end else begin
            if (oStall) begin
                stallRun = stallRun + 1;
            end else if (stallRun > 0) begin
                checks = checks + 1;
                if (stallQ.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL stall_len: got unexpected stall of %0d cycles, required none", stallRun);
                end else begin
                    int e;
                    e = stallQ.pop_front();
                    if (e != stallRun) begin
                        errors = errors + 1;
                        $display("FAIL stall_len: got %0d cycles, required %0d", stallRun, e);
                    end
                end
                stallRun = 0;
            end
            pend   = !oStall && instValid;
            bubble = oStall;
        end
    end

    // Result comparison away from the active edge
    always @(negedge clock) begin
        if (bubble) begin
            checks = checks + 1;
            if ({oRegWrite, oMemRead, oMemWrite, oMemToReg, oBranchTaken, oJump} != 6'b0) begin
                errors = errors + 1;
                $display("FAIL bubble: controls got %b, required 000000",
                         {oRegWrite, oMemRead, oMemWrite, oMemToReg, oBranchTaken, oJump});
            end
        end
        if (pend) begin
            checks = checks + 1;
            if (expQ.size() == 0) begin
                errors = errors + 1;
                $display("FAIL result: unexpected result alu=%h", oALUOut);
            end else begin
                resp_t e;
                string n;
                e = expQ.pop_front();
                n = nameQ.pop_front();
                if (actual() !== e) begin
                    errors = errors + 1;
                    $display("FAIL %s: got %h, required %h", n, actual(), e);
                end
            end
        end
    end

    task automatic runOp(input string name, input logic [3:0] ctrl, input logic [31:0] a, b,
                         input logic [31:0] sext, npc, instr, input logic [6:0] flags,
                         input logic [4:0] wr, input logic [31:0] expAlu, input logic expBt,
                         input logic [31:0] expBtgt, expJtgt, input logic isMd, input logic check);
        int n;
        logic s;
        // flags = {src, br, jmp, rw, mr, mw, m2r}
        iALUCtrl = ctrl; iA = a; iB = b; ioutSignEXT = sext; iNPC1 = npc; iInstr = instr;
        {iALUSrc, iBranch, iJump, iRegWrite, iMemRead, iMemWrite, iMemToReg} = flags;
        iwriteRegWire = wr;
        instValid = check;
        if (check) begin
            expQ.push_back('{flags[3], flags[2], flags[1], flags[0], expAlu, (expAlu == 32'd0), b,
                             expBt, expBtgt, flags[4], expJtgt, wr});
            nameQ.push_back(name);
            if (isMd) stallQ.push_back(33);
        end
        n = 0;
        do begin
            @(negedge clock);
            s = oStall;
            @(posedge clock);
            n = n + 1;
        end while (s && n < 40);
        if (s) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s_timeout: stall still high after %0d cycles, required release", name, n);
        end
        #1;
    endtask

    initial begin
        @(posedge clock); #1;
        checks = checks + 1;
        if ({oStall, actual()} != '0) begin
            errors = errors + 1;
            $display("FAIL reset_state: got %h, required all zero", {oStall, actual()});
        end
        reset = 1'b0;

        runOp("add_5_7", 4'b0010, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 7'b0001000, 5'd3,
              32'd12, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        runOp("sub_branch", 4'b0110, 32'h1234, 32'h1234, 32'd4, 32'h100, 32'd0, 7'b0100000, 5'd0,
              32'd0, 1'b1, 32'h110, 32'd0, 1'b0, 1'b1);
        runOp("nor_jump", 4'b1100, 32'h0F0F0000, 32'h00F0F00F, 32'd0, 32'h30000004, 32'h0A000040,
              7'b0010000, 5'd0, 32'hF0000FF0, 1'b0, 32'h30000004, 32'h38000100, 1'b0, 1'b1);
        runOp("undef_code", 4'b0011, 32'd5, 32'd6, 32'd0, 32'd0, 32'd0, 7'b0100000, 5'd0,
              32'd0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1);
        runOp("mul_6_7", 4'b1000, 32'd6, 32'd7, 32'd0, 32'd0, 32'd0, 7'b0001000, 5'd9,
              32'd42, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        runOp("divu_100_7", 4'b1001, 32'd100, 32'd7, 32'd0, 32'd0, 32'd0, 7'b0001000, 5'd10,
              32'd14, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        runOp("divu_5_0", 4'b1001, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 7'b0101000, 5'd11,
              32'hFFFFFFFF, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);

        // MUL aborted by reset while BUSY with cnt=10
        iALUCtrl = 4'b1000; iA = 32'hFFFFFFFF; iB = 32'd2; iALUSrc = 1'b0; iBranch = 1'b0;
        iJump = 1'b0; iRegWrite = 1'b1; iMemRead = 1'b0; iMemWrite = 1'b0; iMemToReg = 1'b0;
        iwriteRegWire = 5'd12; instValid = 1'b1;
        repeat (11) @(posedge clock);
        #1;
        reset = 1'b1;
        instValid = 1'b0;
        #1;
        checks = checks + 1;
        if (oStall !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL stall_in_reset: got %b, required 0", oStall);
        end
        @(posedge clock); #1;
        checks = checks + 1;
        if ({oStall, actual()} != '0) begin
            errors = errors + 1;
            $display("FAIL abort_reset: got %h, required all zero", {oStall, actual()});
        end
        iALUCtrl = 4'b0000; iA = 32'd0; iB = 32'd0; iRegWrite = 1'b0; iwriteRegWire = 5'd0;
        reset = 1'b0;
        @(posedge clock); #1;
        checks = checks + 1;
        if (oRegWrite !== 1'b0 || oStall !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL abort_writeback: regwrite=%b stall=%b, required 0 0", oRegWrite, oStall);
        end

        runOp("add_imm", 4'b0010, 32'd3, 32'd9, 32'd4, 32'd0, 32'd0, 7'b1001101, 5'd4,
              32'd7, 1'b0, 32'd16, 32'd0, 1'b0, 1'b1);
        runOp("slt_neg", 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 7'b0001000, 5'd5,
              32'd1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        runOp("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 7'b0001000, 5'd6,
              32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

        instValid = 1'b0;
        iALUCtrl = 4'b0000; iRegWrite = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks = checks + 1;
        if (expQ.size() != 0 || stallQ.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: results left %0d stalls left %0d, required 0 0", expQ.size(), stallQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
